// File: rtl/armleocpu_mul_unit.sv
// Sequential shift-and-add multiplier: retires STEP product bits per cycle on
// operand magnitudes, then restores the sign in a final DONE cycle.
module armleocpu_mul_unit #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid,
   input  logic [1:0]           mode,
   input  logic [WIDTH-1:0]     factor0,
   input  logic [WIDTH-1:0]     factor1,
   input  logic                 kill,
   output logic                 busy,
   output logic                 ready,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CNT_W = $clog2(WIDTH/STEP + 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // WIDTH+1 bits so the most-negative operand yields its exact magnitude.
   function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v, input logic is_neg);
      logic [WIDTH:0] m;
      if (is_neg) begin
         m = {(WIDTH+1){1'b0}} - {1'b1, v};
      end else begin
         m = {1'b0, v};
      end
      return m;
   endfunction

   logic [1:0]           state_q,  state_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;
   logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
   logic [WIDTH:0]       mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q,    acc_d;
   logic                 neg_q,    neg_d;
   logic                 ready_q,  ready_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic                 neg0_s, neg1_s;
   logic [WIDTH:0]       mag0_s, mag1_s;
   logic [2*WIDTH-1:0]   pp_s;

   assign neg0_s = ((mode == 2'b01) || (mode == 2'b10)) && factor0[WIDTH-1];
   assign neg1_s = (mode == 2'b01) && factor1[WIDTH-1];
   assign mag0_s = magnitude(factor0, neg0_s);
   assign mag1_s = magnitude(factor1, neg1_s);
   assign pp_s   = mcand_q * {{(2*WIDTH-STEP){1'b0}}, mplier_q[STEP-1:0]};

   assign busy   = (state_q == CALC) || (state_q == DONE);
   assign ready  = ready_q;
   assign result = result_q;

   // Next-state and datapath computation.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      ready_d  = 1'b0;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (valid && !kill) begin
               state_d  = CALC;
               cnt_d    = CNT_W'(WIDTH/STEP);
               mcand_d  = {{(WIDTH-1){1'b0}}, mag0_s};
               mplier_d = mag1_s;
               acc_d    = {(2*WIDTH){1'b0}};
               neg_d    = neg0_s ^ neg1_s;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               acc_d    = acc_q + pp_s;
               mplier_d = mplier_q >> STEP;
               mcand_d  = mcand_q << STEP;
               cnt_d    = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_q == CNT_W'(1)) begin
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!kill) begin
               ready_d = 1'b1;
               if (neg_q) begin
                  result_d = ~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1};
               end else begin
                  result_d = acc_q;
               end
            end else begin
               ready_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset is asynchronous and active-high on rst_n.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         mcand_q  <= {(2*WIDTH){1'b0}};
         mplier_q <= {(WIDTH+1){1'b0}};
         acc_q    <= {(2*WIDTH){1'b0}};
         neg_q    <= 1'b0;
         ready_q  <= 1'b0;
         result_q <= {(2*WIDTH){1'b0}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         ready_q  <= ready_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_armleocpu_mul_unit.sv
// Directed and randomized checks of armleocpu_mul_unit against an arithmetic
// product model, for the default 32x32 build and a 16-bit STEP=4 build.
module tb_armleocpu_mul_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [31:0] factor0 = 32'd0;
   logic [31:0] factor1 = 32'd0;
   logic        kill = 1'b0;
   logic        busy, ready;
   logic [63:0] result;

   logic        valid16 = 1'b0;
   logic [1:0]  mode16 = 2'b00;
   logic [15:0] f0_16 = 16'd0;
   logic [15:0] f1_16 = 16'd0;
   logic        busy16, ready16;
   logic [31:0] result16;

   int n_vec = 0;
   int n_err = 0;

   armleocpu_mul_unit #(.WIDTH(32), .STEP(1)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .mode(mode),
      .factor0(factor0), .factor1(factor1), .kill(kill),
      .busy(busy), .ready(ready), .result(result)
   );

   armleocpu_mul_unit #(.WIDTH(16), .STEP(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .valid(valid16), .mode(mode16),
      .factor0(f0_16), .factor1(f1_16), .kill(1'b0),
      .busy(busy16), .ready(ready16), .result(result16)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Product of the operands interpreted per mode, wrapped to 64 bits.
   function automatic logic [63:0] model32(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] x, y;
      x = (m == 2'b01 || m == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
      y = (m == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
      return x * y;
   endfunction

   task automatic watch_no_ready(input string tag, input logic [63:0] exp_res);
      logic seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ready !== 1'b0) seen = 1'b1;
      end
      chk({tag, "_no_ready"}, {63'd0, seen}, 64'd0);
      chk({tag, "_result_kept"}, result, exp_res);
   endtask

   // Called at a negedge; vpulse/kill_at are CALC cycle indices, 0 = unused.
   task automatic mul32(input string tag, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b, input int vpulse, input int kill_at);
      logic [63:0] exp_res = model32(m, a, b);
      logic [63:0] prev = result;
      logic        busy_ok = 1'b1;
      int          cnt;
      valid = 1'b1; mode = m; factor0 = a; factor1 = b;
      @(negedge clk);
      valid = 1'b0; factor0 = $urandom; factor1 = $urandom; mode = 2'($urandom);
      cnt = 1;
      while (ready !== 1'b1 && cnt < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         valid = (cnt == vpulse);
         if (cnt == kill_at) begin
            kill = 1'b1;
            @(negedge clk);
            kill = 1'b0;
            chk({tag, "_kill_busy"}, {63'd0, busy}, 64'd0);
            chk({tag, "_kill_ready"}, {63'd0, ready}, 64'd0);
            watch_no_ready(tag, prev);
            return;
         end
         @(negedge clk);
         cnt++;
      end
      valid = 1'b0;
      chk({tag, "_latency"}, 64'(cnt - 1), 64'd33);
      chk({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
      chk({tag, "_result"}, result, exp_res);
      @(negedge clk);
      chk({tag, "_pulse_end"}, {63'd0, ready}, 64'd0);
      chk({tag, "_hold"}, result, exp_res);
   endtask

   initial begin
      logic [1:0]  rm;
      logic [31:0] ra, rb;
      int          cnt;

      #1 rst_n = 1'b1;
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_ready", {63'd0, ready}, 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_result16", {32'd0, result16}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      mul32("first_after_rst", 2'b00, 32'd64, 32'd53, 0, 0);
      chk("basic_const", result, 64'h0000_0000_0000_0D40);

      @(negedge clk); mul32("umax", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      chk("umax_const", result, 64'hFFFF_FFFE_0000_0001);
      @(negedge clk); mul32("smin1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      chk("smin1_const", result, 64'h0000_0000_0000_0001);
      @(negedge clk); mul32("smostneg", 2'b01, 32'h8000_0000, 32'h8000_0000, 0, 0);
      chk("smostneg_const", result, 64'h4000_0000_0000_0000);
      @(negedge clk); mul32("mixed", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      chk("mixed_const", result, 64'hFFFF_FFFF_0000_0001);
      @(negedge clk); mul32("mode11", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      chk("mode11_const", result, 64'hFFFF_FFFE_0000_0001);
      @(negedge clk); mul32("zero_s", 2'b01, 32'd0, 32'h8000_0000, 0, 0);
      @(negedge clk); mul32("mixneg", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

      for (int i = 0; i < 16; i++) begin
         rm = 2'($urandom); ra = $urandom; rb = $urandom;
         @(negedge clk); mul32("rand", rm, ra, rb, 0, 0);
      end

      // A request strobed mid-calculation must not disturb the running product.
      @(negedge clk); mul32("vpulse", 2'b01, 32'h1234_5678, 32'hFEDC_BA98, 5, 0);
      @(negedge clk); mul32("kill", 2'b00, 32'h0BAD_F00D, 32'h0000_0777, 0, 10);

      @(negedge clk);
      valid = 1'b1; kill = 1'b1; factor0 = 32'd9; factor1 = 32'd9;
      @(negedge clk);
      valid = 1'b0; kill = 1'b0;
      chk("killvalid_busy", {63'd0, busy}, 64'd0);
      watch_no_ready("killvalid", model32(2'b01, 32'h1234_5678, 32'hFEDC_BA98));

      @(negedge clk);
      valid = 1'b1; mode = 2'b00; factor0 = 32'd1000; factor1 = 32'd1000;
      @(negedge clk);
      valid = 1'b0;
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_ready", {63'd0, ready}, 64'd0);
      chk("midrst_result", result, 64'd0);
      @(negedge clk);
      rst_n = 1'b0;
      watch_no_ready("midrst", 64'd0);

      @(negedge clk);
      valid16 = 1'b1; mode16 = 2'b01; f0_16 = 16'hFFFE; f1_16 = 16'h0003;
      @(negedge clk);
      valid16 = 1'b0; f0_16 = 16'd0; f1_16 = 16'd0;
      cnt = 1;
      while (ready16 !== 1'b1 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("w16_latency", 64'(cnt - 1), 64'd5);
      chk("w16_result", {32'd0, result16}, 64'h0000_0000_FFFF_FFFA);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
